// File: rtl/reg_file_wb_ctrl.sv
// Register file write-port controller: req0/req1 writeback arbitration, req1 FIFO, pending-write scoreboard.
// Optional direct req1 grant when the FIFO is empty: define REG_FILE_WB_CTRL_BYPASS_EN.
module reg_file_wb_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SEL_WIDTH    = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid_i,
    input  logic [SEL_WIDTH-1:0]     req0_sel_i,
    input  logic [DATA_WIDTH-1:0]    req0_data_i,
    input  logic                     req1_valid_i,
    output logic                     req1_ready_o,
    input  logic [SEL_WIDTH-1:0]     req1_sel_i,
    input  logic [DATA_WIDTH-1:0]    req1_data_i,
    input  logic                     issue_valid_i,
    input  logic [SEL_WIDTH-1:0]     issue_sel_i,
    input  logic [SEL_WIDTH-1:0]     chk_sel_ra_i,
    input  logic [SEL_WIDTH-1:0]     chk_sel_rb_i,
    input  logic [SEL_WIDTH-1:0]     chk_sel_rc_i,
    input  logic [SEL_WIDTH-1:0]     chk_sel_dst_i,
    output logic                     hazard_o,
    output logic                     stall_o,
    output logic [2**SEL_WIDTH-1:0]  pending_o,
    output logic                     wr_en_o,
    output logic [SEL_WIDTH-1:0]     wr_sel_o,
    output logic [DATA_WIDTH-1:0]    wr_data_o
);

    localparam int unsigned NUM_REGS = 2**SEL_WIDTH;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W    = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_REQ0 = 2'd1,
        SRC_REQ1 = 2'd2
    } src_e;

    logic [SEL_WIDTH-1:0]  fifo_sel  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [STV_W-1:0]      stv_q, stv_nxt;
    logic [NUM_REGS-1:0]   pending_q, pending_nxt;
    src_e                  wr_src_q, grant_src;
    logic                  fifo_empty, fifo_full, push, pop, bypass;
    logic [SEL_WIDTH-1:0]  grant_sel;
    logic [DATA_WIDTH-1:0] grant_data;

    assign fifo_empty   = (cnt_q == '0);
    assign fifo_full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign req1_ready_o = !fifo_full;

`ifdef REG_FILE_WB_CTRL_BYPASS_EN
    assign bypass = req1_valid_i && fifo_empty && !req0_valid_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = req1_valid_i && !fifo_full && !bypass;
    assign pop  = !req0_valid_i && !fifo_empty;

    always_comb begin
        grant_src  = SRC_NONE;
        grant_sel  = '0;
        grant_data = '0;
        if (req0_valid_i) begin
            grant_src  = SRC_REQ0;
            grant_sel  = req0_sel_i;
            grant_data = req0_data_i;
        end else if (pop) begin
            grant_src  = SRC_REQ1;
            grant_sel  = fifo_sel[rd_ptr_q];
            grant_data = fifo_data[rd_ptr_q];
        end else if (bypass) begin
            grant_src  = SRC_REQ1;
            grant_sel  = req1_sel_i;
            grant_data = req1_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sel[wr_ptr_q]  <= req1_sel_i;
            fifo_data[wr_ptr_q] <= req1_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Clear lands on the edge the register file captures the req1 data; a same-edge issue re-sets it.
    always_comb begin
        pending_nxt = pending_q;
        if (wr_en_o && (wr_src_q == SRC_REQ1))
            pending_nxt[wr_sel_o] = 1'b0;
        if (issue_valid_i && (issue_sel_i != '0))
            pending_nxt[issue_sel_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    assign pending_o = pending_q;
    assign hazard_o  = pending_q[chk_sel_ra_i] | pending_q[chk_sel_rb_i] |
                       pending_q[chk_sel_rc_i] | pending_q[chk_sel_dst_i];

    // A non-empty FIFO that does not pop can only mean req0 took the port this cycle.
    always_comb begin
        stv_nxt = stv_q;
        if (fifo_empty || pop)
            stv_nxt = '0;
        else if (stv_q != STV_W'(STARVE_LIMIT))
            stv_nxt = stv_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            stv_q     <= '0;
            stall_o   <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_sel_o  <= '0;
            wr_data_o <= '0;
            wr_src_q  <= SRC_NONE;
        end else begin
            pending_q <= pending_nxt;
            stv_q     <= stv_nxt;
            stall_o   <= (stv_nxt == STV_W'(STARVE_LIMIT));
            wr_en_o   <= (grant_src != SRC_NONE) && (grant_sel != '0);
            wr_src_q  <= grant_src;
            if (grant_src != SRC_NONE) begin
                wr_sel_o  <= grant_sel;
                wr_data_o <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wb_ctrl.sv
// Directed-vector bench for reg_file_wb_ctrl; follows REG_FILE_WB_CTRL_BYPASS_EN if defined.
module tb_reg_file_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid_i, req1_valid_i, issue_valid_i;
    logic [3:0]  req0_sel_i, req1_sel_i, issue_sel_i;
    logic [31:0] req0_data_i, req1_data_i;
    logic [3:0]  chk_sel_ra_i, chk_sel_rb_i, chk_sel_rc_i, chk_sel_dst_i;
    logic        req1_ready_o, hazard_o, stall_o, wr_en_o;
    logic [15:0] pending_o;
    logic [3:0]  wr_sel_o;
    logic [31:0] wr_data_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    reg_file_wb_ctrl #(
        .DATA_WIDTH(32), .SEL_WIDTH(4), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_sel_i(req0_sel_i), .req0_data_i(req0_data_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_sel_i(req1_sel_i), .req1_data_i(req1_data_i),
        .issue_valid_i(issue_valid_i), .issue_sel_i(issue_sel_i),
        .chk_sel_ra_i(chk_sel_ra_i), .chk_sel_rb_i(chk_sel_rb_i),
        .chk_sel_rc_i(chk_sel_rc_i), .chk_sel_dst_i(chk_sel_dst_i),
        .hazard_o(hazard_o), .stall_o(stall_o), .pending_o(pending_o),
        .wr_en_o(wr_en_o), .wr_sel_o(wr_sel_o), .wr_data_o(wr_data_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] sel, input logic [31:0] data);
        check({tag, "_en"}, 64'(wr_en_o), 64'(en));
        if (en) begin
            check({tag, "_sel"}, 64'(wr_sel_o), 64'(sel));
            check({tag, "_data"}, 64'(wr_data_o), 64'(data));
        end
    endtask

    task automatic idle_inputs();
        req0_valid_i = 0; req0_sel_i = '0; req0_data_i = '0;
        req1_valid_i = 0; req1_sel_i = '0; req1_data_i = '0;
        issue_valid_i = 0; issue_sel_i = '0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        chk_sel_ra_i = '0; chk_sel_rb_i = '0; chk_sel_rc_i = '0; chk_sel_dst_i = '0;
        tick(); tick();
        rst_n = 1;
        tick();
        check("rst_wr_en", 64'(wr_en_o), 0);
        check("rst_wr_sel", 64'(wr_sel_o), 0);
        check("rst_wr_data", 64'(wr_data_o), 0);
        check("rst_stall", 64'(stall_o), 0);
        check("rst_pending", 64'(pending_o), 0);
        check("rst_ready", 64'(req1_ready_o), 1);

        // 1: plain req0 write, one-cycle latency, single cycle
        req0_valid_i = 1; req0_sel_i = 4'd3; req0_data_i = 32'hDEADBEEF;
        tick();
        req0_valid_i = 0;
        check_wr("t1_wr", 1, 4'd3, 32'hDEADBEEF);
        tick();
        check_wr("t1_idle", 0, '0, '0);

        // 2: issue/clear of r5 through req1
        issue_valid_i = 1; issue_sel_i = 4'd5;
        tick();
        issue_valid_i = 0;
        check("t2_pend_set", 64'(pending_o[5]), 1);
        chk_sel_ra_i = 4'd5;
        #1 check("t2_haz_before", 64'(hazard_o), 1);
        req1_valid_i = 1; req1_sel_i = 4'd5; req1_data_i = 32'h1234;
        check("t2_ready", 64'(req1_ready_o), 1);
        tick();
        req1_valid_i = 0;
`ifndef REG_FILE_WB_CTRL_BYPASS_EN
        check_wr("t2_nowr_yet", 0, '0, '0);
        tick();
`endif
        check_wr("t2_wr", 1, 4'd5, 32'h1234);
        check("t2_pend_hold", 64'(pending_o[5]), 1);
        check("t2_haz_hold", 64'(hazard_o), 1);
        tick();
        check("t2_pend_clr", 64'(pending_o[5]), 0);
        check("t2_haz_after", 64'(hazard_o), 0);
        check_wr("t2_idle", 0, '0, '0);
        chk_sel_ra_i = '0;

        // 3: fill FIFO behind req0, hold a 5th beat, drain in order
        req0_valid_i = 1; req0_sel_i = 4'd1; req0_data_i = 32'h11;
        for (int i = 0; i < 4; i++) begin
            req1_valid_i = 1; req1_sel_i = 4'(8 + i); req1_data_i = 32'hA0 + 32'(i);
            check($sformatf("t3_ready%0d", i), 64'(req1_ready_o), 1);
            tick();
        end
        check("t3_full", 64'(req1_ready_o), 0);
        check_wr("t3_req0", 1, 4'd1, 32'h11);
        req1_sel_i = 4'd12; req1_data_i = 32'hA4;
        tick(); tick();
        check("t3_full_hold", 64'(req1_ready_o), 0);
        req0_valid_i = 0;
        tick();
        check_wr("t3_pop0", 1, 4'd8, 32'hA0);
        check("t3_ready_again", 64'(req1_ready_o), 1);
        tick();
        req1_valid_i = 0;
        check_wr("t3_pop1", 1, 4'd9, 32'hA1);
        for (int i = 2; i < 5; i++) begin
            tick();
            check_wr($sformatf("t3_pop%0d", i), 1, 4'(8 + i), 32'hA0 + 32'(i));
        end
        tick();
        check_wr("t3_empty", 0, '0, '0);

        // 4: starvation stall
        req0_valid_i = 1; req0_sel_i = 4'd2; req0_data_i = 32'h22;
        req1_valid_i = 1; req1_sel_i = 4'd13; req1_data_i = 32'h55;
        tick();
        req1_valid_i = 0;
        for (int i = 0; i < 7; i++) tick();
        check("t4_stall_7", 64'(stall_o), 0);
        tick();
        check("t4_stall_8", 64'(stall_o), 1);
        tick();
        check("t4_stall_sat", 64'(stall_o), 1);
        req0_valid_i = 0;
        tick();
        check_wr("t4_pop", 1, 4'd13, 32'h55);
        check("t4_stall_drop", 64'(stall_o), 0);

        // 5: set wins over same-edge clear; register 0 never written
        issue_valid_i = 1; issue_sel_i = 4'd7;
        tick();
        issue_valid_i = 0;
        req1_valid_i = 1; req1_sel_i = 4'd7; req1_data_i = 32'h77;
        tick();
        req1_valid_i = 0;
`ifndef REG_FILE_WB_CTRL_BYPASS_EN
        tick();
`endif
        check_wr("t5_wr7", 1, 4'd7, 32'h77);
        issue_valid_i = 1; issue_sel_i = 4'd7;
        tick();
        issue_valid_i = 0;
        check("t5_set_wins", 64'(pending_o[7]), 1);
        req0_valid_i = 1; req0_sel_i = 4'd0; req0_data_i = 32'h99;
        tick();
        req0_valid_i = 0;
        check("t5_req0_r0", 64'(wr_en_o), 0);
        req1_valid_i = 1; req1_sel_i = 4'd0; req1_data_i = 32'h98;
        tick();
        req1_valid_i = 0;
`ifndef REG_FILE_WB_CTRL_BYPASS_EN
        tick();
`endif
        check("t5_req1_r0", 64'(wr_en_o), 0);
        issue_valid_i = 1; issue_sel_i = 4'd0;
        tick();
        issue_valid_i = 0;
        check("t5_pend0", 64'(pending_o[0]), 0);
        tick();
        check("t5_r0_popped", 64'(req1_ready_o), 1);

        // 6: async reset mid-drain
        req0_valid_i = 1; req0_sel_i = 4'd4; req0_data_i = 32'h44;
        for (int i = 0; i < 3; i++) begin
            req1_valid_i = 1; req1_sel_i = 4'(9 + i); req1_data_i = 32'hC0 + 32'(i);
            tick();
        end
        req1_valid_i = 0; req0_valid_i = 0;
        tick();
        check_wr("t6_pop0", 1, 4'd9, 32'hC0);
        #2 rst_n = 0;
        #1;
        check("t6_rst_wr_en", 64'(wr_en_o), 0);
        check("t6_rst_wr_sel", 64'(wr_sel_o), 0);
        check("t6_rst_wr_data", 64'(wr_data_o), 0);
        check("t6_rst_stall", 64'(stall_o), 0);
        check("t6_rst_pending", 64'(pending_o), 0);
        #2 rst_n = 1;
        tick();
        check("t6_ready", 64'(req1_ready_o), 1);
        check("t6_pending", 64'(pending_o), 0);
        check("t6_flushed", 64'(wr_en_o), 0);
        tick();
        check("t6_flushed2", 64'(wr_en_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
